// File: rtl/reg_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_pkg
// Description : Shared widths, byte-enable encodings and the load tag type
//               used by the register-file write-back controller.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_writeback_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int BE_W       = 2;
  localparam int TAG_W      = REG_ADDR_W + BE_W;

  localparam logic [BE_W-1:0] BE_LO   = 2'b01;
  localparam logic [BE_W-1:0] BE_HI   = 2'b10;
  localparam logic [BE_W-1:0] BE_WORD = 2'b11;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [BE_W-1:0]       byte_en;
  } tag_t;

  // An all-zero enable carries no meaning on the bus, so it becomes a word write.
  function automatic logic [BE_W-1:0] norm_be(input logic [BE_W-1:0] be);
    logic [BE_W-1:0] v;
    v = be;
    if (be == 2'b00) v = BE_WORD;
    return v;
  endfunction

  // Steer data onto the enabled lanes; disabled lanes read as zero.
  function automatic logic [DATA_W-1:0] lane_data(input logic [BE_W-1:0] be,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] v;
    v = '0;
    if ((be & BE_HI) != 2'b00) v[15:8] = d[15:8];
    if ((be & BE_LO) != 2'b00) v[7:0]  = d[7:0];
    return v;
  endfunction

endpackage : reg_writeback_pkg
`default_nettype wire

// File: rtl/reg_writeback_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_tag_fifo
// Description : In-order tag FIFO for outstanding loads. Each slot carries a
//               valid bit so every live entry can be compared against the two
//               decode source addresses in parallel.
// Ports       : i_push/i_tag    - enqueue a tag (ignored when full without pop)
//               i_pop           - dequeue oldest (ignored when empty)
//               o_head          - oldest tag
//               o_empty/o_full  - occupancy flags
//               i_cmp_addr1/2   - addresses to match against live entries
//               o_hit1/2_vec    - per-entry match vectors
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tag_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic                  i_pop,
  output logic [TAG_W-1:0]      o_head,
  output logic                  o_empty,
  output logic                  o_full,
  input  logic [REG_ADDR_W-1:0] i_cmp_addr1,
  input  logic [REG_ADDR_W-1:0] i_cmp_addr2,
  output logic [DEPTH-1:0]      o_hit1_vec,
  output logic [DEPTH-1:0]      o_hit2_vec
);

  localparam int PTR_W = $clog2(DEPTH);

  tag_t             r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  logic w_do_pop;
  logic w_do_push;

  // Entries are contiguous from the read pointer, so the slot under each
  // pointer alone tells empty and full.
  assign o_empty   = !r_valid[r_rd_ptr];
  assign o_full    = r_valid[r_wr_ptr];
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      // When full, both pointers address the same slot; the later set wins.
      if (w_do_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= tag_t'(i_tag);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign o_hit1_vec[gi] = r_valid[gi] && (r_mem[gi].dst == i_cmp_addr1);
    assign o_hit2_vec[gi] = r_valid[gi] && (r_mem[gi].dst == i_cmp_addr2);
  end

endmodule : wb_tag_fifo
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Write-side controller for the 16x16 register file. Merges
//               execute results, in-order load returns and address
//               post-updates onto the byte-laned reg3 port and the full-word
//               reg4 port, and flags read-after-write hazards to decode.
// Ports       : ex_*       - execute request (valid/ready handshake)
//               mem_*      - load data return for the oldest outstanding load
//               rd_addr1/2 - decode source registers, rd_hazard result
//               reg3_*     - byte-laned write port (registered)
//               reg4_*     - full-word write port (registered)
//               loads_full - load tag FIFO full
//               err_unexp  - sticky: load data with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LOAD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [BE_W-1:0]       ex_byte_en,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  ex_addr_wr,
  input  logic [REG_ADDR_W-1:0] ex_addr_reg,
  input  logic [DATA_W-1:0]     ex_addr_data,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  rd_hazard,
  output logic                  reg3_writeu,
  output logic                  reg3_writel,
  output logic [REG_ADDR_W-1:0] reg3_addr,
  output logic [DATA_W-1:0]     reg3_bus,
  output logic                  reg4_write,
  output logic [REG_ADDR_W-1:0] reg4_addr,
  output logic [DATA_W-1:0]     reg4_bus,
  output logic                  loads_full,
  output logic                  err_unexp
);

  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [TAG_W-1:0]      w_head_bits;
  tag_t                  w_head;
  tag_t                  w_push_tag;
  logic [LOAD_DEPTH-1:0] w_hit1_vec;
  logic [LOAD_DEPTH-1:0] w_hit2_vec;

  logic                  w_acc;
  logic                  w_push;
  logic                  w_pop;

  logic [BE_W-1:0]       w_r3_be;
  logic [REG_ADDR_W-1:0] w_r3_addr;
  logic [DATA_W-1:0]     w_r3_raw;
  logic [DATA_W-1:0]     w_r3_bus;
  logic                  w_r4_wr;

  logic                  r_reg3_writeu;
  logic                  r_reg3_writel;
  logic [REG_ADDR_W-1:0] r_reg3_addr;
  logic [DATA_W-1:0]     r_reg3_bus;
  logic                  r_reg4_write;
  logic [REG_ADDR_W-1:0] r_reg4_addr;
  logic [DATA_W-1:0]     r_reg4_bus;
  logic                  r_err_unexp;

  // Memory returns own reg3 outright; a load request may still go alongside
  // a return, since it only touches the FIFO (and a pop frees a slot).
  assign ex_ready = !(mem_valid && !ex_load) && !(ex_load && w_fifo_full && !mem_valid);
  assign w_acc    = ex_valid && ex_ready;
  assign w_push   = w_acc && ex_load;
  assign w_pop    = mem_valid && !w_fifo_empty;

  assign w_push_tag.dst     = ex_dst;
  assign w_push_tag.byte_en = norm_be(ex_byte_en);
  assign w_head             = tag_t'(w_head_bits);

  wb_tag_fifo #(
    .DEPTH (LOAD_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_tag       (w_push_tag),
    .i_pop       (w_pop),
    .o_head      (w_head_bits),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .i_cmp_addr1 (rd_addr1),
    .i_cmp_addr2 (rd_addr2),
    .o_hit1_vec  (w_hit1_vec),
    .o_hit2_vec  (w_hit2_vec)
  );

  always_comb begin
    w_r3_be   = 2'b00;
    w_r3_addr = '0;
    w_r3_raw  = '0;
    if (w_pop) begin
      w_r3_be   = w_head.byte_en;
      w_r3_addr = w_head.dst;
      w_r3_raw  = mem_data;
    end else if (w_acc && !ex_load) begin
      w_r3_be   = norm_be(ex_byte_en);
      w_r3_addr = ex_dst;
      w_r3_raw  = ex_data;
    end
    w_r4_wr = w_acc && ex_addr_wr;
    // Same target on both ports in one cycle: the full-word address update wins.
    if (w_r4_wr && (ex_addr_reg == w_r3_addr)) w_r3_be = 2'b00;
    w_r3_bus = lane_data(w_r3_be, w_r3_raw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg3_writeu <= 1'b0;
      r_reg3_writel <= 1'b0;
      r_reg3_addr   <= '0;
      r_reg3_bus    <= '0;
      r_reg4_write  <= 1'b0;
      r_reg4_addr   <= '0;
      r_reg4_bus    <= '0;
      r_err_unexp   <= 1'b0;
    end else begin
      r_reg3_writeu <= w_r3_be[1];
      r_reg3_writel <= w_r3_be[0];
      r_reg3_addr   <= w_r3_addr;
      r_reg3_bus    <= w_r3_bus;
      r_reg4_write  <= w_r4_wr;
      r_reg4_addr   <= w_r4_wr ? ex_addr_reg : '0;
      r_reg4_bus    <= w_r4_wr ? ex_addr_data : '0;
      if (mem_valid && w_fifo_empty) r_err_unexp <= 1'b1;
    end
  end

  // A write still in flight to the file counts as pending for decode.
  assign rd_hazard = (|w_hit1_vec) || (|w_hit2_vec)
                  || ((r_reg3_writeu || r_reg3_writel)
                      && ((r_reg3_addr == rd_addr1) || (r_reg3_addr == rd_addr2)))
                  || (r_reg4_write
                      && ((r_reg4_addr == rd_addr1) || (r_reg4_addr == rd_addr2)));

  assign reg3_writeu = r_reg3_writeu;
  assign reg3_writel = r_reg3_writel;
  assign reg3_addr   = r_reg3_addr;
  assign reg3_bus    = r_reg3_bus;
  assign reg4_write  = r_reg4_write;
  assign reg4_addr   = r_reg4_addr;
  assign reg4_bus    = r_reg4_bus;
  assign loads_full  = w_fifo_full;
  assign err_unexp   = r_err_unexp;

endmodule : reg_writeback
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Directed self-checking bench for reg_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_load;
  logic [3:0]  ex_dst;
  logic [1:0]  ex_byte_en;
  logic [15:0] ex_data;
  logic        ex_addr_wr;
  logic [3:0]  ex_addr_reg;
  logic [15:0] ex_addr_data;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        rd_hazard;
  logic        reg3_writeu;
  logic        reg3_writel;
  logic [3:0]  reg3_addr;
  logic [15:0] reg3_bus;
  logic        reg4_write;
  logic [3:0]  reg4_addr;
  logic [15:0] reg4_bus;
  logic        loads_full;
  logic        err_unexp;

  int checks;
  int failures;

  reg_writeback #(.LOAD_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_load      (ex_load),
    .ex_dst       (ex_dst),
    .ex_byte_en   (ex_byte_en),
    .ex_data      (ex_data),
    .ex_addr_wr   (ex_addr_wr),
    .ex_addr_reg  (ex_addr_reg),
    .ex_addr_data (ex_addr_data),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_hazard    (rd_hazard),
    .reg3_writeu  (reg3_writeu),
    .reg3_writel  (reg3_writel),
    .reg3_addr    (reg3_addr),
    .reg3_bus     (reg3_bus),
    .reg4_write   (reg4_write),
    .reg4_addr    (reg4_addr),
    .reg4_bus     (reg4_bus),
    .loads_full   (loads_full),
    .err_unexp    (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_load = 0; ex_dst = 0; ex_byte_en = 2'b11; ex_data = 0;
    ex_addr_wr = 0; ex_addr_reg = 0; ex_addr_data = 0;
    mem_valid = 0; mem_data = 0; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; ex_valid = 1; ex_dst = 5; ex_data = 16'h5555;
    tick(); tick(); tick();
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b00) begin failures++; $display("FAIL rst_reg3_strobes got=%b exp=00", {reg3_writeu, reg3_writel}); end
    checks++; if (reg4_write !== 1'b0) begin failures++; $display("FAIL rst_reg4_write got=%b exp=0", reg4_write); end
    checks++; if (reg3_bus !== 16'h0 || reg3_addr !== 4'h0) begin failures++; $display("FAIL rst_reg3_bus_addr got=%h/%h exp=0000/0", reg3_bus, reg3_addr); end
    checks++; if (reg4_bus !== 16'h0 || reg4_addr !== 4'h0) begin failures++; $display("FAIL rst_reg4_bus_addr got=%h/%h exp=0000/0", reg4_bus, reg4_addr); end
    checks++; if (loads_full !== 1'b0 || err_unexp !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", loads_full, err_unexp); end
    ex_valid = 0;
    rst_n = 1;
    tick();
    ex_valid = 1; ex_load = 0; ex_dst = 5; ex_byte_en = 2'b11; ex_data = 16'hBEEF;
    tick();
    ex_valid = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b11) begin failures++; $display("FAIL word_strobes got=%b exp=11", {reg3_writeu, reg3_writel}); end
    checks++; if (reg3_addr !== 4'd5 || reg3_bus !== 16'hBEEF) begin failures++; $display("FAIL word_addr_bus got=%h/%h exp=5/beef", reg3_addr, reg3_bus); end
    tick();
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b00) begin failures++; $display("FAIL word_pulse got=%b exp=00", {reg3_writeu, reg3_writel}); end
  endtask

  task automatic test_load_hazard();
    ex_valid = 1; ex_load = 1; ex_dst = 3; ex_byte_en = 2'b01; rd_addr1 = 3;
    #1;
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL ld_ready got=%b exp=1", ex_ready); end
    tick();
    ex_valid = 0; ex_load = 0;
    checks++; if (rd_hazard !== 1'b1) begin failures++; $display("FAIL ld_hazard_pending got=%b exp=1", rd_hazard); end
    tick(); tick();
    checks++; if (rd_hazard !== 1'b1 || {reg3_writeu, reg3_writel} !== 2'b00) begin failures++; $display("FAIL ld_hazard_hold got=%b/%b exp=1/00", rd_hazard, {reg3_writeu, reg3_writel}); end
    mem_valid = 1; mem_data = 16'h12AB;
    tick();
    mem_valid = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b01) begin failures++; $display("FAIL ld_lo_strobes got=%b exp=01", {reg3_writeu, reg3_writel}); end
    checks++; if (reg3_addr !== 4'd3 || reg3_bus !== 16'h00AB) begin failures++; $display("FAIL ld_lo_addr_bus got=%h/%h exp=3/00ab", reg3_addr, reg3_bus); end
    checks++; if (rd_hazard !== 1'b1) begin failures++; $display("FAIL ld_hazard_inflight got=%b exp=1", rd_hazard); end
    tick();
    checks++; if (rd_hazard !== 1'b0) begin failures++; $display("FAIL ld_hazard_clear got=%b exp=0", rd_hazard); end
    rd_addr1 = 0;
  endtask

  task automatic test_full_fifo();
    ex_valid = 1; ex_load = 1; ex_byte_en = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      ex_dst = 4'(i);
      tick();
    end
    checks++; if (loads_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", loads_full); end
    ex_dst = 5;
    #1;
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL full_stall got=%b exp=0", ex_ready); end
    mem_valid = 1; mem_data = 16'h1111;
    #1;
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL full_pushpop_ready got=%b exp=1", ex_ready); end
    tick();
    ex_valid = 0; ex_load = 0;
    checks++; if (reg3_addr !== 4'd1 || reg3_bus !== 16'h1111 || {reg3_writeu, reg3_writel} !== 2'b11) begin failures++; $display("FAIL full_pop1 got=%h/%h/%b exp=1/1111/11", reg3_addr, reg3_bus, {reg3_writeu, reg3_writel}); end
    checks++; if (loads_full !== 1'b1) begin failures++; $display("FAIL full_after_pushpop got=%b exp=1", loads_full); end
    for (int i = 2; i <= 5; i++) begin
      mem_data = 16'(i * 16'h1111);
      tick();
      checks++; if (reg3_addr !== 4'(i) || reg3_bus !== 16'(i * 16'h1111)) begin failures++; $display("FAIL full_pop_order got=%h/%h exp=%h/%h", reg3_addr, reg3_bus, 4'(i), 16'(i * 16'h1111)); end
    end
    mem_valid = 0;
    checks++; if (loads_full !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", loads_full); end
    tick();
  endtask

  task automatic test_mem_priority();
    ex_valid = 1; ex_load = 1; ex_dst = 9; ex_byte_en = 2'b10;
    tick();
    ex_load = 0; ex_dst = 6; ex_byte_en = 2'b11; ex_data = 16'hCAFE;
    mem_valid = 1; mem_data = 16'hABCD;
    #1;
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL prio_stall got=%b exp=0", ex_ready); end
    tick();
    mem_valid = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b10 || reg3_addr !== 4'd9 || reg3_bus !== 16'hAB00) begin failures++; $display("FAIL prio_mem_write got=%b/%h/%h exp=10/9/ab00", {reg3_writeu, reg3_writel}, reg3_addr, reg3_bus); end
    #1;
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL prio_ready_after got=%b exp=1", ex_ready); end
    tick();
    ex_valid = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b11 || reg3_addr !== 4'd6 || reg3_bus !== 16'hCAFE) begin failures++; $display("FAIL prio_ex_write got=%b/%h/%h exp=11/6/cafe", {reg3_writeu, reg3_writel}, reg3_addr, reg3_bus); end
    tick();
  endtask

  task automatic test_collision();
    ex_valid = 1; ex_load = 0; ex_dst = 7; ex_byte_en = 2'b11; ex_data = 16'h1234;
    ex_addr_wr = 1; ex_addr_reg = 7; ex_addr_data = 16'h0100;
    tick();
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b00) begin failures++; $display("FAIL coll_reg3_suppressed got=%b exp=00", {reg3_writeu, reg3_writel}); end
    checks++; if (reg4_write !== 1'b1 || reg4_addr !== 4'd7 || reg4_bus !== 16'h0100) begin failures++; $display("FAIL coll_reg4 got=%b/%h/%h exp=1/7/0100", reg4_write, reg4_addr, reg4_bus); end
    ex_addr_reg = 8; ex_addr_data = 16'h0200; ex_byte_en = 2'b00;
    tick();
    ex_valid = 0; ex_addr_wr = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b11 || reg3_addr !== 4'd7 || reg3_bus !== 16'h1234) begin failures++; $display("FAIL dual_reg3 got=%b/%h/%h exp=11/7/1234", {reg3_writeu, reg3_writel}, reg3_addr, reg3_bus); end
    checks++; if (reg4_write !== 1'b1 || reg4_addr !== 4'd8 || reg4_bus !== 16'h0200) begin failures++; $display("FAIL dual_reg4 got=%b/%h/%h exp=1/8/0200", reg4_write, reg4_addr, reg4_bus); end
    rd_addr2 = 8;
    #1;
    checks++; if (rd_hazard !== 1'b1) begin failures++; $display("FAIL reg4_hazard got=%b exp=1", rd_hazard); end
    tick();
    checks++; if (reg4_write !== 1'b0 || rd_hazard !== 1'b0) begin failures++; $display("FAIL reg4_pulse got=%b/%b exp=0/0", reg4_write, rd_hazard); end
    rd_addr2 = 0;
  endtask

  task automatic test_unexpected();
    mem_valid = 1; mem_data = 16'hDEAD;
    tick();
    mem_valid = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b00 || err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_set got=%b/%b exp=00/1", {reg3_writeu, reg3_writel}, err_unexp); end
    tick(); tick();
    checks++; if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_sticky got=%b exp=1", err_unexp); end
    rst_n = 0;
    #1;
    checks++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL unexp_clear got=%b exp=0", err_unexp); end
    tick();
    rst_n = 1;
    tick();
    ex_valid = 1; ex_load = 1; ex_dst = 2; ex_byte_en = 2'b11; rd_addr1 = 2;
    tick();
    ex_valid = 0; ex_load = 0;
    checks++; if (rd_hazard !== 1'b1) begin failures++; $display("FAIL discard_pending got=%b exp=1", rd_hazard); end
    rst_n = 0;
    #1;
    rst_n = 1;
    #1;
    checks++; if (rd_hazard !== 1'b0) begin failures++; $display("FAIL discard_hazard got=%b exp=0", rd_hazard); end
    mem_valid = 1; mem_data = 16'h7777;
    tick();
    mem_valid = 0;
    checks++; if ({reg3_writeu, reg3_writel} !== 2'b00 || err_unexp !== 1'b1) begin failures++; $display("FAIL discard_unexp got=%b/%b exp=00/1", {reg3_writeu, reg3_writel}, err_unexp); end
    rd_addr1 = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_hazard();
    test_full_fifo();
    test_mem_priority();
    test_collision();
    test_unexpected();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_writeback
`default_nettype wire

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side controller for the 16x16 CPU register file.
- Merges execute-stage results (D_Bus), in-order memory load returns and address post-update writes (D_Addr).
- Drives the file's two write ports: byte-laned reg3 and full-word reg4.
- Tracks outstanding load destinations and flags read-after-write hazards to decode.

Parameters:
- LOAD_DEPTH, 4, max outstanding loads; power of two, >=2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute result request
- ex_ready  out  1  request accepted this cycle when ex_valid&&ex_ready
- ex_load  in  1  1: reserve load slot, no reg3 write now; 0: write ex_data now
- ex_dst  in  4  destination register
- ex_byte_en  in  2  [1]=upper byte, [0]=lower byte; 2'b00 illegal, treated as 2'b11
- ex_data  in  16  result for non-load
- ex_addr_wr  in  1  address post-update write, qualified by ex_valid&&ex_ready
- ex_addr_reg  in  4  register receiving address update
- ex_addr_data  in  16  new address value
- mem_valid  in  1  load data returning (oldest outstanding load)
- mem_data  in  16  load data; lane per slot byte_en, lower-byte-only loads use mem_data[7:0]
- rd_addr1  in  4  decode R_Bus source
- rd_addr2  in  4  decode S_Bus source
- rd_hazard  out  1  either source pending (combinational)
- reg3_writeu  out  1  upper-byte strobe
- reg3_writel  out  1  lower-byte strobe
- reg3_addr  out  4
- reg3_bus  out  16
- reg4_write  out  1
- reg4_addr  out  4
- reg4_bus  out  16
- loads_full  out  1  load tag FIFO full
- err_unexp  out  1  sticky: mem_valid with no outstanding load

Behaviour:
- Reset (async, rst_n low): all strobes 0; addr/bus outputs 0; FIFO empty; err_unexp 0; loads_full 0. Reset mid-operation discards pending loads with no writes; later mem_valid then sets err_unexp.
- All regfile-side outputs are registered. Writes appear one cycle after acceptance and land in the file on the following edge. Strobes are single-cycle pulses.
- Load tag FIFO holds {dst, byte_en}, LOAD_DEPTH entries, wrap-around pointers.
  - ex_load accepted: push.
  - mem_valid: pop oldest, drive reg3 from mem_data with that entry's lane strobes.
- reg3 arbitration: memory return has absolute priority and is never back-pressured.
- ex_ready = !(mem_valid && !ex_load) && !(ex_load && FIFO full && !mem_valid).
  - Load push and pop in the same cycle are allowed when full.
  - Addr-only traffic still needs ex_ready.
- reg3 data path: byte_en 2'b01 drives reg3_writel only, data [7:0] in bus[7:0]. 2'b10 drives reg3_writeu only, data [15:8] in bus[15:8]. Unused lanes are driven 0.
- reg4 path: ex_addr_wr accepted gives reg4_write=1 next cycle with ex_addr_reg/ex_addr_data. This is independent of reg3 activity.
- Same-cycle collision (reg3 target == reg4 target): reg3 strobes are suppressed, reg4 full word wins. Deterministic, no error.
- rd_hazard = 1 if rd_addr1 or rd_addr2 matches:
  - any valid FIFO entry, or
  - the registered reg3 target with a strobe set, or
  - the registered reg4 target with reg4_write set.
  - A register with multiple outstanding loads stays hazardous until its last entry pops.
- err_unexp sets on mem_valid with an empty FIFO (no write issued). It clears only on reset.

Decomposition:
- Shared package: REG_ADDR_W=4, DATA_W=16; byte-enable encodings BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11; tag struct {dst, byte_en}.
- One sub-module: wb_tag_fifo (parameterised sync FIFO with per-entry compare vector for hazard matching).

Test Plan:
- Reset with ex_valid=1, ex_dst=5: all strobes 0 while rst_n low. Release, then ex_load=0, dst=5, be=11, data=16'hBEEF: next cycle reg3_writeu=writel=1, addr=5, bus=BEEF.
- ex_load dst=3 be=01, then rd_addr1=3: rd_hazard=1 until mem_valid with mem_data=16'h12AB. Next cycle only reg3_writel=1, bus=16'h00AB. Hazard drops the cycle after.
- Push 4 loads (dst 1..4): loads_full=1, 5th load ex_ready=0. Same-cycle mem_valid: ex_ready=1, push+pop, count stays 4. Pops return dst 1,2,3,4 in order.
- mem_valid together with non-load ex_valid: ex_ready=0, memory write issued, ex accepted next cycle unchanged.
- ex non-load dst=7 plus ex_addr_wr reg=7 data=16'h0100: reg3 strobes 0, reg4_write=1 addr 7 bus 0100. With reg=8 instead, both ports fire.
- mem_valid with empty FIFO: no strobes, err_unexp=1 and held until rst_n low.
